// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit saturating direction
// counters, combinational lookup in IF and registered update from EX.
module branch_predictor (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] if_pc_i,
    output logic        pred_taken_o,
    output logic        pred_hit_o,
    output logic [15:0] pred_target_o,
    input  logic        upd_en_i,
    input  logic [15:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [15:0] upd_target_i,
    input  logic        upd_wrong_i,
    input  logic        stall_i,
    output logic [15:0] mispred_cnt_o,
    output logic [15:0] branch_cnt_o
);

    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam logic [1:0]  CTR_ALLOC = 2'b10;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic        valid_q  [16];
    logic [11:0] tag_q    [16];
    logic [15:0] target_q [16];
    logic [1:0]  ctr_q    [16];

    logic [15:0] branch_cnt_q;
    logic [15:0] mispred_cnt_q;

    logic [3:0]  lookup_idx;
    logic [11:0] lookup_tag;
    logic        lookup_hit;
    logic        lookup_taken;
    logic [15:0] lookup_fallthrough;

    logic [3:0]  upd_idx;
    logic [11:0] upd_tag;
    logic        upd_fire;
    logic        upd_hit;
    logic [1:0]  upd_ctr_cur;
    logic [1:0]  upd_ctr_next;

    // Lookup reads the registered table only, so a same-cycle update is not seen
    always_comb begin
        lookup_idx         = if_pc_i[3:0];
        lookup_tag         = if_pc_i[15:4];
        lookup_fallthrough = if_pc_i + 16'd1;
        lookup_hit         = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        lookup_taken       = lookup_hit && ctr_q[lookup_idx][1];
    end

    assign pred_hit_o    = lookup_hit;
    assign pred_taken_o  = lookup_taken;
    assign pred_target_o = lookup_taken ? target_q[lookup_idx] : lookup_fallthrough;

    always_comb begin
        upd_idx      = upd_pc_i[3:0];
        upd_tag      = upd_pc_i[15:4];
        upd_fire     = upd_en_i && !stall_i;
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_ctr_cur  = ctr_q[upd_idx];
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken_i) begin
            if (upd_ctr_cur != 2'b11) begin
                upd_ctr_next = upd_ctr_cur + 2'd1;
            end
        end else begin
            if (upd_ctr_cur != 2'b00) begin
                upd_ctr_next = upd_ctr_cur - 2'd1;
            end
        end
    end

    // Reset wins over stall and over any update presented in the same cycle
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 16; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= 12'd0;
                target_q[i] <= 16'd0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (upd_fire) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (upd_taken_i) begin
                    target_q[upd_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target_i;
                ctr_q[upd_idx]    <= CTR_ALLOC;
            end
        end
    end

    // Statistics counters stick at all-ones instead of wrapping
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else if (upd_fire) begin
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (upd_wrong_i && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic, compared against a behavioural table model.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [15:0] if_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic [15:0] pred_target;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_wrong;
    logic        stall;
    logic [15:0] mispred_cnt;
    logic [15:0] branch_cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit valid;
        int tag;
        int target;
        int ctr;
    } entry_t;

    entry_t modelTable [16];
    int     modelBranch;
    int     modelMispred;

    branch_predictor dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .if_pc_i       (if_pc),
        .pred_taken_o  (pred_taken),
        .pred_hit_o    (pred_hit),
        .pred_target_o (pred_target),
        .upd_en_i      (upd_en),
        .upd_pc_i      (upd_pc),
        .upd_taken_i   (upd_taken),
        .upd_target_i  (upd_target),
        .upd_wrong_i   (upd_wrong),
        .stall_i       (stall),
        .mispred_cnt_o (mispred_cnt),
        .branch_cnt_o  (branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) begin
            modelTable[i] = '{valid: 1'b0, tag: 0, target: 0, ctr: 1};
        end
        modelBranch  = 0;
        modelMispred = 0;
    endfunction

    // Behavioural view: a branch with a known tag nudges its confidence; an
    // unknown taken branch claims its slot; an unknown not-taken branch is ignored
    function automatic void modelUpdate(input int pc, input bit taken, input int target, input bit wrong);
        int idx;
        int tg;
        idx = pc % 16;
        tg  = pc / 16;
        if (modelTable[idx].valid && modelTable[idx].tag == tg) begin
            if (taken) begin
                modelTable[idx].ctr    = (modelTable[idx].ctr >= 3) ? 3 : modelTable[idx].ctr + 1;
                modelTable[idx].target = target;
            end else begin
                modelTable[idx].ctr = (modelTable[idx].ctr <= 0) ? 0 : modelTable[idx].ctr - 1;
            end
        end else if (taken) begin
            modelTable[idx] = '{valid: 1'b1, tag: tg, target: target, ctr: 2};
        end
        if (modelBranch < 65535) modelBranch++;
        if (wrong && modelMispred < 65535) modelMispred++;
    endfunction

    task automatic checkOutput(input string tag);
        int  idx;
        bit  expHit;
        bit  expTaken;
        int  expTarget;
        idx       = int'(if_pc) % 16;
        expHit    = modelTable[idx].valid && (modelTable[idx].tag == int'(if_pc) / 16);
        expTaken  = expHit && (modelTable[idx].ctr >= 2);
        expTarget = expTaken ? modelTable[idx].target : (int'(if_pc) + 1) % 65536;
        checkValue({tag, ".hit"},    {15'd0, pred_hit},   {15'd0, expHit});
        checkValue({tag, ".taken"},  {15'd0, pred_taken}, {15'd0, expTaken});
        checkValue({tag, ".target"}, pred_target,         16'(expTarget));
    endtask

    task automatic checkCounters(input string tag);
        checkValue({tag, ".branch_cnt"},  branch_cnt,  16'(modelBranch));
        checkValue({tag, ".mispred_cnt"}, mispred_cnt, 16'(modelMispred));
    endtask

    // One clock cycle: drive at negedge, check the lookup before the edge,
    // advance the model at the edge, check the counters after it
    task automatic applyStimulus(input string tag, input logic [15:0] pc, input bit en,
                                 input logic [15:0] uPc, input bit taken, input logic [15:0] uTgt,
                                 input bit wrong, input bit stl, input bit rstn, input bit doCheck);
        if_pc      = pc;
        upd_en     = en;
        upd_pc     = uPc;
        upd_taken  = taken;
        upd_target = uTgt;
        upd_wrong  = wrong;
        stall      = stl;
        rst        = rstn;
        #1;
        if (doCheck) checkOutput(tag);
        @(posedge clk);
        if (!rstn) modelReset();
        else if (en && !stl) modelUpdate(int'(uPc), taken, int'(uTgt), wrong);
        @(negedge clk);
        if (doCheck) checkCounters(tag);
    endtask

    initial begin
        modelReset();
        rst = 1'b0; if_pc = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_wrong = 1'b0; stall = 1'b0;
        @(negedge clk);

        // Reset and idle lookup
        applyStimulus("reset0", 16'h0025, 1'b1, 16'h0025, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("reset1", 16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("idle",   16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("idle.target_literal", pred_target, 16'h0026);

        // First taken branch allocates; visible one cycle later
        applyStimulus("alloc",    16'h0025, 1'b1, 16'h0025, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("alloc.rd", 16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("alloc.target_literal", pred_target, 16'h0040);
        checkValue("alloc.branch_literal", branch_cnt, 16'd1);

        // Counter walks down, saturates up, then back down
        for (int i = 0; i < 2; i++)
            applyStimulus("dec", 16'h0025, 1'b1, 16'h0025, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("dec.rd", 16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("dec.hit_literal",   {15'd0, pred_hit},   16'd1);
        checkValue("dec.taken_literal", {15'd0, pred_taken}, 16'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus("inc", 16'h0025, 1'b1, 16'h0025, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus("sat.dec", 16'h0025, 1'b1, 16'h0025, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("sat.rd", 16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Aliasing at index 5 replaces the older tag
        applyStimulus("alias",     16'h0025, 1'b1, 16'h0135, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("alias.old", 16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("alias.new", 16'h0135, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("alias.target_literal", pred_target, 16'h0200);

        // Stalled update with misprediction is dropped, then accepted
        applyStimulus("stall",   16'h0135, 1'b1, 16'h0135, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("unstall", 16'h0135, 1'b1, 16'h0135, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("unstall.rd", 16'h0135, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Same-cycle lookup/update at index 5 shows old contents first
        applyStimulus("bypass.old", 16'h0235, 1'b1, 16'h0235, 1'b1, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("bypass.new", 16'h0235, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("bypass.target_literal", pred_target, 16'h0300);

        // Reset during a stall with a pending update clears everything
        applyStimulus("midreset",    16'h0235, 1'b1, 16'h0235, 1'b1, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus("midreset.rd", 16'h0235, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic over a small tag range so hits and aliasing are frequent
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rPc;
            logic [15:0] rUpc;
            rPc  = 16'($urandom_range(0, 63));
            rUpc = 16'($urandom_range(0, 63));
            applyStimulus("rand", rPc, 1'($urandom), rUpc, 1'($urandom), 16'($urandom),
                          1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) != 0), 1'b1);
        end

        // Drive both counters past all-ones
        applyStimulus("preset", 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65538; i++)
            applyStimulus("fill", 16'($urandom), 1'b1, 16'($urandom), 1'($urandom), 16'($urandom),
                          1'b1, 1'b0, 1'b1, 1'b0);
        checkCounters("sat");
        checkValue("sat.branch_literal",  branch_cnt,  16'hFFFF);
        checkValue("sat.mispred_literal", mispred_cnt, 16'hFFFF);
        applyStimulus("sat.hold", 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
